bus_cycle_controller: RTL and testbench

- Sits directly downstream of the address decoder, between the RISC-V core's data/instruction bus and the ROM, RAM, IO and graphics targets.
- Consumes the four one-hot select lines and turns one CPU request into a timed target access.
- Fixed-wait targets (ROM, IO, graphics) get a programmable number of wait states; RAM gets an ack handshake with a timeout.
- Returns muxed read data, a one-cycle `cpu_ready` pulse, and a bus error for unmapped addresses or timeouts.

---
 rtl/bus_pkg.sv | 36 +++
 rtl/bus_cycle_controller_if.sv | 23 ++
 rtl/bus_rdata_mux.sv | 24 ++
 rtl/bus_cycle_controller.sv | 176 +++++++++++++++++
 tb/tb_bus_cycle_controller.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the CPU-side bus cycle controller: FSM states,
// target identifiers and the default wait-state constants.
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FIXED   = 3'd1,
    RAMWAIT = 3'd2,
    DONE    = 3'd3,
    ERR     = 3'd4
  } bus_state_t;

  // Values 1..4 line up with the cs strobe index + 1 (ROM, RAM, IO, GFX).
  typedef enum logic [2:0] {
    TGT_NONE = 3'd0,
    TGT_ROM  = 3'd1,
    TGT_RAM  = 3'd2,
    TGT_IO   = 3'd3,
    TGT_GFX  = 3'd4
  } target_t;

  localparam int DEFAULT_ROM_WAIT    = 1;
  localparam int DEFAULT_IO_WAIT     = 2;
  localparam int DEFAULT_GFX_WAIT    = 1;
  localparam int DEFAULT_RAM_TIMEOUT = 255;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/bus_cycle_controller_if.sv
// CPU request/response channel between the core and the bus cycle controller.
interface bus_cycle_controller_if;

  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_err;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  cpu_rdata, cpu_ready, cpu_err
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output cpu_rdata, cpu_ready, cpu_err
  );

endinterface

// File: rtl/bus_rdata_mux.sv
// Combinational read-data selector: forwards the latched target's read data.
module bus_rdata_mux
  import bus_pkg::*;
(
  input  target_t     target,
  input  logic [31:0] rom_rdata,
  input  logic [31:0] ram_rdata,
  input  logic [31:0] io_rdata,
  input  logic [31:0] gfx_rdata,
  output logic [31:0] rdata
);

  always_comb begin
    rdata = '0;
    case (target)
      TGT_ROM: rdata = rom_rdata;
      TGT_RAM: rdata = ram_rdata;
      TGT_IO:  rdata = io_rdata;
      TGT_GFX: rdata = gfx_rdata;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/bus_cycle_controller.sv
// Turns one CPU request into a timed ROM/RAM/IO/graphics access: fixed wait
// states for ROM/IO/GFX, ack handshake with timeout for RAM, bus error otherwise.
module bus_cycle_controller
  import bus_pkg::*;
#(
  parameter int ROM_WAIT    = DEFAULT_ROM_WAIT,
  parameter int IO_WAIT     = DEFAULT_IO_WAIT,
  parameter int GFX_WAIT    = DEFAULT_GFX_WAIT,
  parameter int RAM_TIMEOUT = DEFAULT_RAM_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        reset,
  bus_cycle_controller_if.slave       cpu,
  input  logic                        ROM_Select_H,
  input  logic                        RAM_Select_H,
  input  logic                        IO_Select_H,
  input  logic                        Graphics_Select_H,
  output logic [31:0]                 bus_addr,
  output logic [31:0]                 bus_wdata,
  output logic [3:0]                  bus_be,
  output logic                        bus_we,
  output logic                        rom_cs,
  output logic                        ram_cs,
  output logic                        io_cs,
  output logic                        gfx_cs,
  input  logic [31:0]                 rom_rdata,
  input  logic [31:0]                 ram_rdata,
  input  logic [31:0]                 io_rdata,
  input  logic [31:0]                 gfx_rdata,
  input  logic                        ram_ack
);

  localparam int CNT_MAX = max_of4(ROM_WAIT, IO_WAIT, GFX_WAIT, RAM_TIMEOUT);
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  typedef logic [CNT_W-1:0] cnt_t;

  bus_state_t  state_reg,     state_next;
  cnt_t        count_reg,     count_next;
  target_t     target_reg,    target_next;
  logic [31:0] bus_addr_reg,  bus_addr_next;
  logic [31:0] bus_wdata_reg, bus_wdata_next;
  logic [3:0]  bus_be_reg,    bus_be_next;
  logic        bus_we_reg,    bus_we_next;
  logic [31:0] rdata_reg,     rdata_next;

  logic [31:0] target_rdata;
  logic [3:0]  cs_vec;
  logic        access_active;

  bus_rdata_mux u_rdata_mux (
    .target    (target_reg),
    .rom_rdata (rom_rdata),
    .ram_rdata (ram_rdata),
    .io_rdata  (io_rdata),
    .gfx_rdata (gfx_rdata),
    .rdata     (target_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      target_reg    <= TGT_NONE;
      bus_addr_reg  <= '0;
      bus_wdata_reg <= '0;
      bus_be_reg    <= '0;
      bus_we_reg    <= 1'b0;
      rdata_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      target_reg    <= target_next;
      bus_addr_reg  <= bus_addr_next;
      bus_wdata_reg <= bus_wdata_next;
      bus_be_reg    <= bus_be_next;
      bus_we_reg    <= bus_we_next;
      rdata_reg     <= rdata_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    target_next    = target_reg;
    bus_addr_next  = bus_addr_reg;
    bus_wdata_next = bus_wdata_reg;
    bus_be_next    = bus_be_reg;
    bus_we_next    = bus_we_reg;
    rdata_next     = rdata_reg;

    case (state_reg)
      IDLE: begin
        rdata_next = '0;
        if (cpu.cpu_req) begin
          bus_addr_next  = cpu.cpu_addr;
          bus_wdata_next = cpu.cpu_wdata;
          bus_be_next    = cpu.cpu_be;
          bus_we_next    = cpu.cpu_we;
          state_next     = FIXED;
          // Overlapping decodes resolve as ROM > IO > GFX > RAM.
          if (ROM_Select_H) begin
            target_next = TGT_ROM;
            count_next  = cnt_t'(ROM_WAIT);
          end else if (IO_Select_H) begin
            target_next = TGT_IO;
            count_next  = cnt_t'(IO_WAIT);
          end else if (Graphics_Select_H) begin
            target_next = TGT_GFX;
            count_next  = cnt_t'(GFX_WAIT);
          end else if (RAM_Select_H) begin
            target_next = TGT_RAM;
            count_next  = '0;
            state_next  = RAMWAIT;
          end else begin
            target_next = TGT_NONE;
            state_next  = ERR;
          end
        end
      end

      FIXED: begin
        if (count_reg != '0) begin
          count_next = count_reg - cnt_t'(1);
        end else begin
          rdata_next = bus_we_reg ? 32'd0 : target_rdata;
          state_next = DONE;
        end
      end

      RAMWAIT: begin
        // An ack in the final timeout cycle still completes normally.
        if (ram_ack) begin
          rdata_next = target_rdata;
          state_next = DONE;
        end else if (count_reg == cnt_t'(RAM_TIMEOUT)) begin
          rdata_next = '0;
          state_next = ERR;
        end else begin
          count_next = count_reg + cnt_t'(1);
        end
      end

      DONE, ERR: begin
        rdata_next = '0;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign access_active = (state_reg == FIXED) || (state_reg == RAMWAIT);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cs
      assign cs_vec[gi] = access_active && (target_reg == target_t'(3'(gi + 1)));
    end
  endgenerate

  assign rom_cs = cs_vec[0];
  assign ram_cs = cs_vec[1];
  assign io_cs  = cs_vec[2];
  assign gfx_cs = cs_vec[3];

  assign bus_addr  = bus_addr_reg;
  assign bus_wdata = bus_wdata_reg;
  assign bus_be    = bus_be_reg;
  assign bus_we    = bus_we_reg;

  assign cpu.cpu_rdata = rdata_reg;
  assign cpu.cpu_ready = (state_reg == DONE) || (state_reg == ERR);
  assign cpu.cpu_err   = (state_reg == ERR);

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Randomized scoreboard bench for bus_cycle_controller: the driver predicts each
// access's response, strobe length and completion cycle; a negedge monitor checks.
module tb_bus_cycle_controller;

  localparam int ROM_W  = 1;
  localparam int IO_W   = 2;
  localparam int GFX_W  = 1;
  localparam int RAM_TO = 255;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          rdy_cyc;
    int          cs_idx;   // 0 ROM, 1 RAM, 2 IO, 3 GFX, -1 none
    int          cs_len;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rom_sel = 1'b0, ram_sel = 1'b0, io_sel = 1'b0, gfx_sel = 1'b0;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_we;
  logic        rom_cs, ram_cs, io_cs, gfx_cs;
  logic [31:0] rom_rdata = '0, ram_rdata = '0, io_rdata = '0, gfx_rdata = '0;
  logic        ram_ack = 1'b0;

  bus_cycle_controller_if cif ();

  bus_cycle_controller dut (
    .clk               (clk),
    .reset             (reset),
    .cpu               (cif),
    .ROM_Select_H      (rom_sel),
    .RAM_Select_H      (ram_sel),
    .IO_Select_H       (io_sel),
    .Graphics_Select_H (gfx_sel),
    .bus_addr          (bus_addr),
    .bus_wdata         (bus_wdata),
    .bus_be            (bus_be),
    .bus_we            (bus_we),
    .rom_cs            (rom_cs),
    .ram_cs            (ram_cs),
    .io_cs             (io_cs),
    .gfx_cs            (gfx_cs),
    .rom_rdata         (rom_rdata),
    .ram_rdata         (ram_rdata),
    .io_rdata          (io_rdata),
    .gfx_rdata         (gfx_rdata),
    .ram_ack           (ram_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  exp_t        sb_q[$];
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic [3:0]  exp_be = '0;
  logic        exp_we = 1'b0;
  bit          drv_timeout = 1'b0;
  bit          in_done = 1'b0;
  int          n_vec = 0;
  int          n_miss = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: counts strobe cycles, checks latched bus fields and pops on cpu_ready.
  initial begin : monitor
    int         cs_cnt [4];
    logic [3:0] cs_now;
    bit         rst_prev;
    bit         timeout_seen;
    exp_t       e;
    cs_cnt = '{default: 0};
    rst_prev = 1'b0;
    timeout_seen = 1'b0;
    forever begin
      @(negedge clk);
      cs_now = {gfx_cs, io_cs, ram_cs, rom_cs};
      if (rst_prev) begin
        chk("rst_cs", {28'd0, cs_now}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_bus_be_we", {27'd0, bus_be, bus_we}, 32'd0);
        chk("rst_cpu_rdata", cif.cpu_rdata, 32'd0);
        chk("rst_ready_err", {30'd0, cif.cpu_ready, cif.cpu_err}, 32'd0);
      end
      if (reset) begin
        cs_cnt = '{default: 0};
      end else begin
        for (int i = 0; i < 4; i++) if (cs_now[i]) cs_cnt[i]++;
        if (cs_now != 4'd0) begin
          chk("cs_onehot", 32'($countones(cs_now)), 32'd1);
          chk("bus_addr", bus_addr, exp_addr);
          chk("bus_wdata", bus_wdata, exp_wdata);
          chk("bus_be_we", {27'd0, bus_be, bus_we}, {27'd0, exp_be, exp_we});
        end
        if (cif.cpu_ready) begin
          if (sb_q.size() == 0) begin
            chk("spurious_ready", {31'd0, cif.cpu_ready}, 32'd0);
          end else begin
            e = sb_q.pop_front();
            chk("cpu_rdata", cif.cpu_rdata, e.rdata);
            chk("cpu_err", {31'd0, cif.cpu_err}, {31'd0, e.err});
            chk("ready_cycle", 32'(cyc), 32'(e.rdy_cyc));
            for (int i = 0; i < 4; i++)
              chk($sformatf("cs_len[%0d]", i), 32'(cs_cnt[i]), 32'((i == e.cs_idx) ? e.cs_len : 0));
            chk("cs_at_ready", {28'd0, cs_now}, 32'd0);
            cs_cnt = '{default: 0};
          end
        end
      end
      if (drv_timeout && !timeout_seen) begin
        timeout_seen = 1'b1;
        n_vec++;
        n_miss++;
        $display("FAIL ready_wait: no cpu_ready within bound, want one (cycle %0d)", cyc);
      end
      rst_prev = reset;
    end
  end

  task automatic set_sels(input logic [3:0] s);
    {gfx_sel, io_sel, ram_sel, rom_sel} = s;
  endtask

  // Issue one access at posedge+1; 'chained' means the DUT is currently in its
  // DONE/ERR cycle, so acceptance happens one edge later.
  task automatic issue(input logic [3:0] sels, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int ack_k,
                       input bit chained);
    exp_t e;
    int   acc;
    int   tgt;
    int   w;
    bit   done;
    acc = cyc + 1 + (chained ? 1 : 0);
    w = 0;
    if (sels[0])      begin tgt = 0; w = ROM_W; end
    else if (sels[2]) begin tgt = 2; w = IO_W;  end
    else if (sels[3]) begin tgt = 3; w = GFX_W; end
    else if (sels[1]) tgt = 1;
    else              tgt = -1;
    e.cs_idx = tgt;
    e.err = 1'b0;
    if (tgt == -1) begin
      e.rdy_cyc = acc; e.cs_len = 0; e.err = 1'b1; e.rdata = '0;
    end else if (tgt == 1) begin
      if (ack_k >= 1 && ack_k <= RAM_TO + 1) begin
        e.rdy_cyc = acc + ack_k; e.cs_len = ack_k; e.rdata = ram_rdata;
      end else begin
        e.rdy_cyc = acc + RAM_TO + 1; e.cs_len = RAM_TO + 1; e.err = 1'b1; e.rdata = '0;
      end
    end else begin
      e.rdy_cyc = acc + w + 1;
      e.cs_len = w + 1;
      e.rdata = we ? 32'd0 : ((tgt == 0) ? rom_rdata : (tgt == 2) ? io_rdata : gfx_rdata);
    end
    sb_q.push_back(e);
    exp_addr = addr; exp_wdata = wdata; exp_be = be; exp_we = we;
    cif.cpu_req = 1'b1; cif.cpu_we = we; cif.cpu_addr = addr;
    cif.cpu_wdata = wdata; cif.cpu_be = be;
    set_sels(sels);
    done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(posedge clk); #1;
      if (cyc >= acc) begin
        cif.cpu_addr = $urandom(); cif.cpu_wdata = $urandom();
        cif.cpu_be = 4'($urandom()); cif.cpu_we = 1'($urandom());
        set_sels(4'($urandom()));
      end
      if (tgt == 1) ram_ack = (ack_k > 0) && (cyc == acc + ack_k - 1);
      else          ram_ack = 1'($urandom_range(0, 1));
      if (cif.cpu_ready) done = 1'b1;
    end
    ram_ack = 1'b0;
    if (!done) drv_timeout = 1'b1;
  endtask

  task automatic txn(input logic [3:0] sels, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int ack_k,
                     input bit may_chain);
    bit chain;
    chain = may_chain && in_done && ($urandom_range(0, 1) == 1);
    if (in_done && !chain) begin
      cif.cpu_req = 1'b0;
      set_sels(4'd0);
      repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
    issue(sels, we, addr, wdata, be, ack_k, chain);
    in_done = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin : driver
    int          r;
    logic [3:0]  s;
    int          k;
    cif.cpu_req = 1'b0; cif.cpu_we = 1'b0; cif.cpu_addr = '0;
    cif.cpu_wdata = '0; cif.cpu_be = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Directed accesses from the test plan.
    rom_rdata = 32'hDEADBEEF;
    txn(4'b0001, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 0, 1'b0);
    txn(4'b0100, 1'b1, 32'h0040_0010, 32'h0000_00A5, 4'b0001, 0, 1'b0);
    ram_rdata = 32'h1234_5678;
    txn(4'b0010, 1'b0, 32'h0800_0040, 32'h0, 4'hF, 5, 1'b0);
    txn(4'b0010, 1'b0, 32'h0800_0080, 32'h0, 4'hF, 0, 1'b0);
    txn(4'b0000, 1'b0, 32'h0200_0000, 32'h0, 4'hF, 0, 1'b0);

    // Reset in the second io_cs cycle of an IO write: no completion expected.
    cif.cpu_req = 1'b0; set_sels(4'd0);
    @(posedge clk); #1;
    exp_addr = 32'h0040_0020; exp_wdata = 32'h0000_005A; exp_be = 4'b0010; exp_we = 1'b1;
    cif.cpu_req = 1'b1; cif.cpu_we = 1'b1; cif.cpu_addr = exp_addr;
    cif.cpu_wdata = exp_wdata; cif.cpu_be = exp_be; set_sels(4'b0100);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; cif.cpu_req = 1'b0; set_sels(4'd0);
    repeat (6) begin @(posedge clk); #1; end
    in_done = 1'b0;

    rom_rdata = 32'hCAFE_F00D;
    txn(4'b0001, 1'b0, 32'h0000_0200, 32'h0, 4'hF, 0, 1'b0);
    // Overlapping selects and ack landing exactly on the timeout cycle.
    io_rdata = 32'h1111_2222; gfx_rdata = 32'h3333_4444; ram_rdata = 32'h5555_6666;
    txn(4'b1111, 1'b0, 32'h0000_0300, 32'h0, 4'hF, 0, 1'b0);
    txn(4'b1110, 1'b0, 32'h0040_0300, 32'h0, 4'hF, 0, 1'b0);
    txn(4'b1010, 1'b0, 32'h0100_0300, 32'h0, 4'hF, 0, 1'b0);
    txn(4'b0010, 1'b0, 32'h0800_0300, 32'h0, 4'hF, RAM_TO + 1, 1'b0);

    for (int t = 0; t < 60; t++) begin
      rom_rdata = $urandom(); ram_rdata = $urandom();
      io_rdata = $urandom(); gfx_rdata = $urandom();
      r = $urandom_range(0, 9);
      if (r < 8)       s = 4'b0001 << (r % 4);
      else if (r == 8) s = 4'b0000;
      else             s = 4'($urandom());
      k = ($urandom_range(0, 24) == 0) ? 0 : $urandom_range(1, 10);
      txn(s, 1'($urandom()), $urandom(), $urandom(), 4'($urandom()), k, 1'b1);
    end

    cif.cpu_req = 1'b0; set_sels(4'd0);
    repeat (4) begin @(posedge clk); #1; end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
